// File: rtl/reg_file_sb_pkg.sv
// Shared constants and register index names for the reg_file_sb register file.
package reg_file_sb_pkg;

  localparam int unsigned RF_WIDTH   = 8;
  localparam int unsigned RF_DEPTH   = 8;
  localparam int unsigned REG_ADDR_W = 3;

  // Simulation-only timing figures; the RTL itself carries no delays.
  localparam int unsigned READ_DELAY  = 2;
  localparam int unsigned WRITE_DELAY = 1;

  typedef enum logic [REG_ADDR_W-1:0] {
    R0, R1, R2, R3, R4, R5, R6, R7
  } reg_idx_e;

endpackage

// File: rtl/reg_file_sb_pending_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on write-back.
module reg_file_sb_pending_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int unsigned DEPTH = RF_DEPTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_set,
  input  logic [REG_ADDR_W-1:0] i_set_addr,
  input  logic                  i_clr,
  input  logic [REG_ADDR_W-1:0] i_clr_addr,
  input  logic [REG_ADDR_W-1:0] i_addr1,
  input  logic [REG_ADDR_W-1:0] i_addr2,
  input  logic                  i_fwd1,
  input  logic                  i_fwd2,
  output logic                  o_busy1,
  output logic                  o_busy2
);

  logic [DEPTH-1:0] r_pending;
  logic [DEPTH-1:0] w_pending_d;

  // Set is applied after clear so a same-cycle issue marks the new producer outstanding.
  always_comb begin
    w_pending_d = r_pending;
    if (i_clr) w_pending_d[i_clr_addr] = 1'b0;
    if (i_set) w_pending_d[i_set_addr] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_pending <= '0;
    else         r_pending <= w_pending_d;
  end

  assign o_busy1 = r_pending[i_addr1] & ~i_fwd1;
  assign o_busy2 = r_pending[i_addr2] & ~i_fwd2;

endmodule

// File: rtl/reg_file_sb.sv
// 8x8 register file feeding the ALU, with two read ports, one write port,
// optional write-to-read forwarding and a pending-write scoreboard.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int unsigned WIDTH  = RF_WIDTH,
  parameter int unsigned DEPTH  = RF_DEPTH,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [WIDTH-1:0]      IN,
  input  logic [REG_ADDR_W-1:0] INADDRESS,
  input  logic                  WRITE,
  input  logic [REG_ADDR_W-1:0] OUT1ADDRESS,
  input  logic [REG_ADDR_W-1:0] OUT2ADDRESS,
  output logic [WIDTH-1:0]      OUT1,
  output logic [WIDTH-1:0]      OUT2,
  input  logic                  ISSUE,
  input  logic [REG_ADDR_W-1:0] ISSUEADDR,
  output logic                  BUSY1,
  output logic                  BUSY2,
  output logic                  STALL
);

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic             w_hit1;
  logic             w_hit2;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (WRITE) begin
      r_regs[INADDRESS] <= IN;
    end
  end

  // A read hitting the register being written this cycle sees the incoming data.
  assign w_hit1 = BYPASS && WRITE && (INADDRESS == OUT1ADDRESS);
  assign w_hit2 = BYPASS && WRITE && (INADDRESS == OUT2ADDRESS);

  assign OUT1 = w_hit1 ? IN : r_regs[OUT1ADDRESS];
  assign OUT2 = w_hit2 ? IN : r_regs[OUT2ADDRESS];

  reg_file_sb_pending_scoreboard #(
    .DEPTH (DEPTH)
  ) u_scoreboard (
    .i_clk      (CLK),
    .i_reset    (RESET),
    .i_set      (ISSUE),
    .i_set_addr (ISSUEADDR),
    .i_clr      (WRITE),
    .i_clr_addr (INADDRESS),
    .i_addr1    (OUT1ADDRESS),
    .i_addr2    (OUT2ADDRESS),
    .i_fwd1     (w_hit1),
    .i_fwd2     (w_hit2),
    .o_busy1    (BUSY1),
    .o_busy2    (BUSY2)
  );

  assign STALL = BUSY1 | BUSY2;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb; a second instance runs with forwarding disabled.
module tb_reg_file_sb;
  import reg_file_sb_pkg::*;

  logic                  CLK = 1'b0;
  logic                  RESET;
  logic [7:0]            IN;
  logic [REG_ADDR_W-1:0] INADDRESS;
  logic                  WRITE;
  logic [REG_ADDR_W-1:0] OUT1ADDRESS;
  logic [REG_ADDR_W-1:0] OUT2ADDRESS;
  logic                  ISSUE;
  logic [REG_ADDR_W-1:0] ISSUEADDR;

  logic [7:0] out1_b, out2_b, out1_n, out2_n;
  logic       busy1_b, busy2_b, stall_b, busy1_n, busy2_n, stall_n;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  reg_file_sb #(.WIDTH(8), .DEPTH(8), .BYPASS(1'b1)) u_dut (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(out1_b), .OUT2(out2_b),
    .ISSUE(ISSUE), .ISSUEADDR(ISSUEADDR), .BUSY1(busy1_b), .BUSY2(busy2_b), .STALL(stall_b)
  );

  reg_file_sb #(.WIDTH(8), .DEPTH(8), .BYPASS(1'b0)) u_dut_nobyp (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(out1_n), .OUT2(out2_n),
    .ISSUE(ISSUE), .ISSUEADDR(ISSUEADDR), .BUSY1(busy1_n), .BUSY2(busy2_n), .STALL(stall_n)
  );

  // Advance one rising edge and return at the following falling edge.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle();
    RESET = 1'b0; WRITE = 1'b0; ISSUE = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    WRITE = 1'b1; INADDRESS = a; IN = d;
    tick();
    WRITE = 1'b0;
  endtask

  task automatic test_reset();
    do_write(3'd3, 8'h5A);
    OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd3;
    #READ_DELAY;
    checks++;
    if (out1_b !== 8'h5A) begin
      errors++; $display("FAIL reset_preload got %h want %h", out1_b, 8'h5A);
    end
    // Write and issue in the reset cycle must both be discarded.
    RESET = 1'b1; WRITE = 1'b1; INADDRESS = 3'd3; IN = 8'hFF; ISSUE = 1'b1; ISSUEADDR = 3'd3;
    tick();
    idle();
    #READ_DELAY;
    checks++;
    if (out1_b !== 8'h00) begin
      errors++; $display("FAIL reset_out1 got %h want %h", out1_b, 8'h00);
    end
    checks++;
    if (out2_n !== 8'h00) begin
      errors++; $display("FAIL reset_out2_nobyp got %h want %h", out2_n, 8'h00);
    end
    checks++;
    if ({busy1_b, busy2_b, stall_b} !== 3'b000) begin
      errors++; $display("FAIL reset_busy got %b want %b", {busy1_b, busy2_b, stall_b}, 3'b000);
    end
  endtask

  task automatic test_write_read();
    do_write(3'd2, 8'd9);
    do_write(3'd5, 8'hFC);
    OUT1ADDRESS = 3'd2; OUT2ADDRESS = 3'd5;
    #READ_DELAY;
    checks++;
    if (out1_b !== 8'd9) begin
      errors++; $display("FAIL wr_out1 got %h want %h", out1_b, 8'd9);
    end
    checks++;
    if (out2_b !== 8'hFC) begin
      errors++; $display("FAIL wr_out2 got %h want %h", out2_b, 8'hFC);
    end
    checks++;
    if (out2_n !== 8'hFC) begin
      errors++; $display("FAIL wr_out2_nobyp got %h want %h", out2_n, 8'hFC);
    end
  endtask

  task automatic test_scoreboard();
    ISSUE = 1'b1; ISSUEADDR = 3'd4;
    tick();
    ISSUE = 1'b0;
    OUT1ADDRESS = 3'd4; OUT2ADDRESS = 3'd2;
    #READ_DELAY;
    checks++;
    if ({busy1_b, busy2_b, stall_b} !== 3'b101) begin
      errors++; $display("FAIL sb_pending got %b want %b", {busy1_b, busy2_b, stall_b}, 3'b101);
    end
    @(negedge CLK);
    WRITE = 1'b1; INADDRESS = 3'd4; IN = 8'd7;
    #READ_DELAY;
    checks++;
    if ({busy1_b, out1_b} !== {1'b0, 8'd7}) begin
      errors++; $display("FAIL sb_bypass_wb got %b/%h want 0/07", busy1_b, out1_b);
    end
    checks++;
    if (busy1_n !== 1'b1 || stall_n !== 1'b1) begin
      errors++; $display("FAIL sb_nobyp_wb got %b%b want 11", busy1_n, stall_n);
    end
    tick();
    WRITE = 1'b0;
    #READ_DELAY;
    checks++;
    if ({busy1_b, stall_b, out1_b} !== {2'b00, 8'd7}) begin
      errors++; $display("FAIL sb_cleared got %b%b/%h want 00/07", busy1_b, stall_b, out1_b);
    end
    checks++;
    if ({busy1_n, out1_n} !== {1'b0, 8'd7}) begin
      errors++; $display("FAIL sb_cleared_nobyp got %b/%h want 0/07", busy1_n, out1_n);
    end
  endtask

  task automatic test_issue_write_same();
    ISSUE = 1'b1; ISSUEADDR = 3'd6; WRITE = 1'b1; INADDRESS = 3'd6; IN = 8'h66;
    tick();
    idle();
    OUT1ADDRESS = 3'd6; OUT2ADDRESS = 3'd6;
    #READ_DELAY;
    checks++;
    if (out1_b !== 8'h66) begin
      errors++; $display("FAIL iw_data got %h want %h", out1_b, 8'h66);
    end
    checks++;
    if ({busy1_b, busy2_b, stall_b} !== 3'b111) begin
      errors++; $display("FAIL iw_pending got %b want %b", {busy1_b, busy2_b, stall_b}, 3'b111);
    end
    do_write(3'd6, 8'h67);
    #READ_DELAY;
    checks++;
    if (stall_b !== 1'b0) begin
      errors++; $display("FAIL iw_clear got %b want %b", stall_b, 1'b0);
    end
  endtask

  task automatic test_bypass();
    do_write(3'd1, 8'h11);
    OUT1ADDRESS = 3'd1; OUT2ADDRESS = 3'd2;
    WRITE = 1'b1; INADDRESS = 3'd1; IN = 8'h3C;
    #READ_DELAY;
    checks++;
    if ({busy1_b, out1_b} !== {1'b0, 8'h3C}) begin
      errors++; $display("FAIL byp_fwd got %b/%h want 0/3c", busy1_b, out1_b);
    end
    checks++;
    if (out1_n !== 8'h11) begin
      errors++; $display("FAIL byp_off_old got %h want %h", out1_n, 8'h11);
    end
    checks++;
    if (out2_b !== 8'd9) begin
      errors++; $display("FAIL byp_other_port got %h want %h", out2_b, 8'd9);
    end
    tick();
    WRITE = 1'b0;
    #READ_DELAY;
    checks++;
    if (out1_n !== 8'h3C) begin
      errors++; $display("FAIL byp_off_new got %h want %h", out1_n, 8'h3C);
    end
  endtask

  task automatic test_dual_port();
    do_write(3'd7, 8'h81);
    OUT1ADDRESS = 3'd7; OUT2ADDRESS = 3'd7;
    #READ_DELAY;
    checks++;
    if (out1_b !== 8'h81 || out2_b !== 8'h81) begin
      errors++; $display("FAIL dual_data got %h/%h want 81/81", out1_b, out2_b);
    end
    @(negedge CLK);
    ISSUE = 1'b1; ISSUEADDR = 3'd7;
    tick();
    // Re-issue while pending: still a single pending bit, cleared by one write.
    tick();
    ISSUE = 1'b0;
    #READ_DELAY;
    checks++;
    if ({busy1_b, busy2_b, stall_b} !== 3'b111) begin
      errors++; $display("FAIL dual_busy got %b want %b", {busy1_b, busy2_b, stall_b}, 3'b111);
    end
    checks++;
    if ({busy1_n, busy2_n} !== 2'b11) begin
      errors++; $display("FAIL dual_busy_nobyp got %b want %b", {busy1_n, busy2_n}, 2'b11);
    end
    @(negedge CLK);
    do_write(3'd7, 8'h00);
    #READ_DELAY;
    checks++;
    if ({busy1_n, busy2_n, stall_n, out1_n} !== {3'b000, 8'h00}) begin
      errors++; $display("FAIL dual_clear got %b%b%b/%h want 000/00", busy1_n, busy2_n, stall_n,
                         out1_n);
    end
  endtask

  initial begin
    IN = '0; INADDRESS = '0; OUT1ADDRESS = '0; OUT2ADDRESS = '0; ISSUEADDR = '0;
    WRITE = 1'b0; ISSUE = 1'b0; RESET = 1'b1;
    @(negedge CLK);
    tick();
    idle();
    test_reset();
    test_write_read();
    test_scoreboard();
    test_issue_write_same();
    test_bypass();
    test_dual_port();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- 8 x 8-bit register file directly upstream of the ALU (logicSelector).
- Supplies the ALU op1/op2 operands through two read ports and accepts the ALU result (or a loaded immediate) on one write port.
- A per-register pending scoreboard flags registers whose ALU write-back is still outstanding, so the control unit can stall dependent reads.
- Single clock domain, CPU-wide.

Parameters:
- WIDTH, 8, data width of each register (matches ALU operand/result width).
- DEPTH, 8, number of registers; address width is log2(DEPTH) = 3.
- READ_DELAY, 2, modelled read-path delay in time units (simulation-only).
- WRITE_DELAY, 1, modelled delay from CLK posedge to register update (simulation-only).
- BYPASS, 1, 1 = same-cycle write data forwarded to a matching read port; 0 = no forwarding.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset, sampled on CLK rising edge.
- IN  input  WIDTH  write data (ALU result or immediate).
- INADDRESS  input  3  write register index.
- WRITE  input  1  write enable.
- OUT1ADDRESS  input  3  read port 1 index (feeds ALU op2/forward path).
- OUT2ADDRESS  input  3  read port 2 index (feeds ALU op1).
- OUT1  output  WIDTH  read port 1 data.
- OUT2  output  WIDTH  read port 2 data.
- ISSUE  input  1  an instruction targeting ISSUEADDR has been issued to the ALU.
- ISSUEADDR  input  3  destination register of the issued instruction.
- BUSY1  output  1  pending bit of OUT1ADDRESS.
- BUSY2  output  1  pending bit of OUT2ADDRESS.
- STALL  output  1  BUSY1 | BUSY2.

Behaviour:
- Storage: DEPTH registers of WIDTH bits plus a DEPTH-bit pending vector.
- Reset:
  - On a CLK rising edge with RESET=1, all registers and all pending bits clear to 0 after WRITE_DELAY.
  - RESET has priority over WRITE and ISSUE in the same cycle.
  - Consequences: OUT1=OUT2=0, BUSY1=BUSY2=STALL=0.
  - Reset mid-operation discards any outstanding write-back; the pending bit clears.
- Write:
  - On a CLK rising edge with WRITE=1 and RESET=0, reg[INADDRESS] <= IN after WRITE_DELAY, and pending[INADDRESS] clears.
  - WRITE=0 leaves all registers unchanged.
- Issue:
  - On a CLK rising edge with ISSUE=1 and RESET=0, pending[ISSUEADDR] is set.
  - If ISSUE and WRITE target the same index in the same cycle, the set wins: the new producer is outstanding.
  - Different indices update independently.
  - Re-issuing an already pending register keeps it pending; there is no counting.
- Read:
  - Combinational, asynchronous on address, register contents or IN. Outputs update READ_DELAY after any change.
  - Both ports may read the same register.
- Bypass (BYPASS=1):
  - If WRITE=1 and INADDRESS equals OUTnADDRESS, OUTn shows IN combinationally and BUSYn reads 0 for that cycle.
  - BYPASS=0: OUTn shows the old value until the register updates, and BUSYn reflects the stored pending bit.
- BUSY/STALL:
  - Combinational from the pending vector, addresses and bypass condition.
  - STALL is not registered, so the control unit sees it in the same cycle.
- Width: values are stored and returned raw. Signedness is interpreted only by the ALU.
- X handling: an unknown address drives X on the corresponding output. Verification must flag this, not mask it.
- Latency: write-to-read-visible is 1 clock edge plus WRITE_DELAY, or 0 cycles via bypass.

Decomposition:
- Shared package/include holds:
  - WIDTH and REG_ADDR_W constants.
  - Timing constants READ_DELAY and WRITE_DELAY.
  - Register index names R0..R7.
- One natural sub-module, pending_scoreboard: the pending vector with set/clear/reset logic and the two BUSY lookups.
- Storage and read muxing stay in reg_file_sb.

Test Plan:
- Reset: load reg3=8'h5A, then assert RESET for one edge -> OUT1 (addr 3)=8'h00, STALL=0; a WRITE in the same cycle as RESET is ignored.
- Basic write/read: WRITE IN=8'd9 to reg2, then IN=-8'sd4 to reg5; read addr1=2, addr2=5 -> OUT1=8'd9, OUT2=8'hFC, each READ_DELAY after address change.
- Scoreboard: ISSUE to reg4, then read addr1=4 -> BUSY1=1, STALL=1; next cycle WRITE reg4=8'd7 -> BUSY1=0, OUT1=8'd7.
- Same-cycle ISSUE and WRITE to reg6 -> reg6 takes the written value, and pending[6] stays 1 (BUSY=1).
- Bypass (BYPASS=1): WRITE reg1=8'h3C with addr1=1 before the edge -> OUT1=8'h3C and BUSY1=0 in that cycle. With BYPASS=0 -> old value until the edge.
- Dual-port same address: addr1=addr2=7 holding 8'h81 -> OUT1=OUT2=8'h81. Pending reg7 -> BUSY1=BUSY2=1.
